// File: rtl/bm_dot_product_lanes.sv
// Multi-lane block-minifloat dot product: exact integer accumulation, one RNE conversion to float.
// Optional define BM_DOT_SUBNORMAL_EN decodes exp==0 elements as subnormals instead of zero.
module bm_dot_product_lanes #(
  parameter int e       = 3,
  parameter int m       = 4,
  parameter int E       = 8,
  parameter int M       = 23,
  parameter int SB_size = 4,
  parameter int LANES   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_beats,
  input  logic signed [SB_size-1:0] shared_bias1,
  input  logic signed [SB_size-1:0] shared_bias2,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*(1+e+m)-1:0]  BM1,
  input  logic [LANES*(1+e+m)-1:0]  BM2,
  output logic                      result_valid,
  output logic [E+M:0]              result,
  output logic                      FLAG_exp_overflow,
  output logic                      busy
);

  localparam int W        = 1 + e + m;
  localparam int BIAS0    = 2**(e-1) - 1;
  localparam int BIASOUT  = 2**(E-1) - 1;
  localparam int SIG_W    = m + 1;
  localparam int KMAX     = 2**e - 2;
  localparam int PW       = 2*SIG_W + 2*KMAX;
  localparam int LG_LANES = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int ACC_W    = PW + CNT_W + LG_LANES + 1;
  localparam int PIDX_W   = $clog2(ACC_W);
  localparam int XW       = 16;

`ifdef BM_DOT_SUBNORMAL_EN
  localparam bit SUBNORM_EN = 1'b1;
`else
  localparam bit SUBNORM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACCUM, NORM, ROUND, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          nbeats_q, nbeats_d;
  logic signed [SB_size-1:0] sb1_q, sb1_d;
  logic signed [SB_size-1:0] sb2_q, sb2_d;
  logic                      sign_q, sign_d;
  logic [ACC_W-1:0]          mag_q, mag_d;
  logic [PIDX_W-1:0]         p_q, p_d;
  logic signed [XW-1:0]      x_q, x_d;
  logic [E+M:0]              result_q, result_d;
  logic                      flag_q, flag_d;

  logic signed [ACC_W-1:0]   lane_prod [LANES];
  logic signed [ACC_W-1:0]   beat_sum;

  // Per-lane decode and exact product, sign applied after the shift.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic                 s1, s2;
    logic [e-1:0]         exp1, exp2;
    logic [m-1:0]         mant1, mant2;
    logic [SIG_W-1:0]     sig1, sig2;
    logic [e-1:0]         k1, k2;
    logic [e:0]           ksum;
    logic [2*SIG_W-1:0]   sig_prod;
    logic [PW-1:0]        lane_mag;
    logic [ACC_W-1:0]     lane_ext;

    assign s1    = BM1[gi*W + W - 1];
    assign s2    = BM2[gi*W + W - 1];
    assign exp1  = BM1[gi*W + m +: e];
    assign exp2  = BM2[gi*W + m +: e];
    assign mant1 = BM1[gi*W +: m];
    assign mant2 = BM2[gi*W +: m];

    assign sig1 = (exp1 != '0) ? {1'b1, mant1} : (SUBNORM_EN ? {1'b0, mant1} : '0);
    assign sig2 = (exp2 != '0) ? {1'b1, mant2} : (SUBNORM_EN ? {1'b0, mant2} : '0);
    assign k1   = (exp1 != '0) ? exp1 - e'(1) : '0;
    assign k2   = (exp2 != '0) ? exp2 - e'(1) : '0;
    assign ksum = {1'b0, k1} + {1'b0, k2};

    assign sig_prod = sig1 * sig2;
    assign lane_mag = {{(PW-2*SIG_W){1'b0}}, sig_prod} << ksum;
    assign lane_ext = {{(ACC_W-PW){1'b0}}, lane_mag};
    assign lane_prod[gi] = (s1 ^ s2) ? -$signed(lane_ext) : $signed(lane_ext);
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + lane_prod[i];
    end
  end

  // Magnitude, leading-one position and unbiased exponent of the finished sum.
  logic [ACC_W-1:0]     abs_acc;
  logic [PIDX_W-1:0]    lead_pos;
  logic signed [XW-1:0] x_norm;

  always_comb begin
    abs_acc  = acc_q[ACC_W-1] ? -acc_q : acc_q;
    lead_pos = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (abs_acc[i]) lead_pos = PIDX_W'(i);
    end
    x_norm = XW'($signed({1'b0, lead_pos})) + XW'(2 - 2*BIAS0 - 2*m)
             - XW'(sb1_q) - XW'(sb2_q);
  end

  // Align so the leading one sits at bit M, then round-to-nearest-even on what falls off.
  logic [M:0]        mant_src;
  logic [PIDX_W-1:0] rsh;
  logic [ACC_W-1:0]  low_mask;
  logic [ACC_W-1:0]  low_bits;
  logic [ACC_W-1:0]  half;
  logic              round_up;
  logic [M+1:0]      mant_rnd;
  logic              carry;
  int                b_exp;
  logic [E+M:0]      round_res;
  logic              round_flag;

  always_comb begin
    mant_src = '0;
    rsh      = '0;
    low_mask = '0;
    low_bits = '0;
    half     = '0;
    round_up = 1'b0;
    if (int'(p_q) > M) begin
      rsh      = p_q - PIDX_W'(M);
      mant_src = (M+1)'(mag_q >> rsh);
      low_mask = (ACC_W'(1) << rsh) - ACC_W'(1);
      low_bits = mag_q & low_mask;
      half     = ACC_W'(1) << (rsh - PIDX_W'(1));
      round_up = (low_bits > half) || ((low_bits == half) && mant_src[0]);
    end else begin
      mant_src = (M+1)'({{M{1'b0}}, mag_q} << (M - int'(p_q)));
    end
    mant_rnd = {1'b0, mant_src} + (M+2)'(round_up);
    carry    = mant_rnd[M+1];
    b_exp    = int'(x_q) + int'(carry) + BIASOUT;

    round_flag = 1'b0;
    if (mag_q == '0) begin
      round_res = '0;
    end else if (b_exp >= 2**E - 1) begin
      round_res  = {sign_q, {E{1'b1}}, {M{1'b0}}};
      round_flag = 1'b1;
    end else if (b_exp <= 0) begin
      round_res = {sign_q, {(E+M){1'b0}}};
    end else begin
      round_res = {sign_q, b_exp[E-1:0], mant_rnd[M-1:0]};
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nbeats_d = nbeats_q;
    sb1_d    = sb1_q;
    sb2_d    = sb2_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    p_d      = p_q;
    x_d      = x_q;
    result_d = result_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          nbeats_d = num_beats;
          sb1_d    = shared_bias1;
          sb2_d    = shared_bias2;
          acc_d    = '0;
          cnt_d    = '0;
          result_d = '0;
          flag_d   = 1'b0;
          state_d  = (num_beats == '0) ? NORM : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + beat_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == nbeats_q) state_d = NORM;
        end
      end
      NORM: begin
        sign_d  = acc_q[ACC_W-1];
        mag_d   = abs_acc;
        p_d     = lead_pos;
        x_d     = x_norm;
        state_d = ROUND;
      end
      ROUND: begin
        result_d = round_res;
        flag_d   = round_flag;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      nbeats_q <= '0;
      sb1_q    <= '0;
      sb2_q    <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      p_q      <= '0;
      x_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nbeats_q <= nbeats_d;
      sb1_q    <= sb1_d;
      sb2_q    <= sb2_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      p_q      <= p_d;
      x_q      <= x_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign in_ready          = (state_q == ACCUM);
  assign busy              = (state_q != IDLE);
  assign result_valid      = (state_q == DONE);
  assign result            = result_q;
  assign FLAG_exp_overflow = flag_q;

endmodule

// File: tb/tb_bm_dot_product_lanes.sv
// Directed bench for bm_dot_product_lanes with hand-computed float results.
module tb_bm_dot_product_lanes;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        num_beats;
  logic signed [3:0] shared_bias1;
  logic signed [3:0] shared_bias2;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       BM1;
  logic [31:0]       BM2;
  logic              result_valid;
  logic [31:0]       result;
  logic              FLAG_exp_overflow;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;

  bm_dot_product_lanes dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .num_beats         (num_beats),
    .shared_bias1      (shared_bias1),
    .shared_bias2      (shared_bias2),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .BM1               (BM1),
    .BM2               (BM2),
    .result_valid      (result_valid),
    .result            (result),
    .FLAG_exp_overflow (FLAG_exp_overflow),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] lanes4(input logic [7:0] l0, input logic [7:0] l1,
                                         input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [7:0] nb, input logic signed [3:0] s1,
                           input logic signed [3:0] s2);
    start        = 1'b1;
    num_beats    = nb;
    shared_bias1 = s1;
    shared_bias2 = s2;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] b);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    BM1      = a;
    BM2      = b;
    tick();
    in_valid = 1'b0;
    BM1      = '0;
    BM2      = '0;
  endtask

  // Called #1 after the edge that took the final beat (or the start edge).
  task automatic wait_result(input string tag, input logic [31:0] exp_res);
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'd2);
    check_eq(tag, result, exp_res);
    check_eq({tag, "_flag"}, 32'(FLAG_exp_overflow), 32'd0);
    tick();
    check_eq({tag, "_pulse"}, 32'(result_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_hold"}, result, exp_res);
    $display("[TB] %s result=%08h expected=%08h", tag, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ones;
    logic [31:0] sub_exp;
    ones         = lanes4(8'h30, 8'h30, 8'h30, 8'h30);
    reset        = 1'b0;
    start        = 1'b0;
    num_beats    = '0;
    shared_bias1 = '0;
    shared_bias2 = '0;
    in_valid     = 1'b0;
    BM1          = '0;
    BM2          = '0;
    tick();
    tick();
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_flag", 32'(FLAG_exp_overflow), 32'd0);
    reset = 1'b1;
    tick();

    // Beat offered while idle must not be taken.
    in_valid = 1'b1;
    BM1      = lanes4(8'h70, 8'h70, 8'h70, 8'h70);
    BM2      = BM1;
    tick();
    check_eq("idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    start_vec(8'd1, 4'sd0, 4'sd0);
    check_eq("s1_busy", 32'(busy), 32'd1);
    beat("s1", ones, ones);
    wait_result("s1_four", 32'h40800000);

    start_vec(8'd1, 4'sd1, 4'sd1);
    beat("s2", ones, ones);
    wait_result("s2_bias", 32'h3F800000);

    start_vec(8'd1, 4'sd0, 4'sd0);
    beat("s3", lanes4(8'h30, 8'hB0, 8'h00, 8'h00), lanes4(8'h30, 8'h30, 8'h00, 8'h00));
    wait_result("s3_cancel", 32'h00000000);

    // 1.5 * 2.0 over three gapped beats, with an ignored start in a gap.
    start_vec(8'd3, 4'sd0, 4'sd0);
    beat("s4a", lanes4(8'h38, 8'h00, 8'h00, 8'h00), lanes4(8'h40, 8'h00, 8'h00, 8'h00));
    tick();
    start     = 1'b1;
    num_beats = 8'd0;
    tick();
    start = 1'b0;
    check_eq("s4_ign_start", 32'(in_ready), 32'd1);
    beat("s4b", lanes4(8'h38, 8'h00, 8'h00, 8'h00), lanes4(8'h40, 8'h00, 8'h00, 8'h00));
    tick();
    tick();
    beat("s4c", lanes4(8'h38, 8'h00, 8'h00, 8'h00), lanes4(8'h40, 8'h00, 8'h00, 8'h00));
    wait_result("s4_nine", 32'h41100000);

`ifdef BM_DOT_SUBNORMAL_EN
    sub_exp = 32'h3C800000;
`else
    sub_exp = 32'h00000000;
`endif
    start_vec(8'd1, 4'sd0, 4'sd0);
    beat("s5", lanes4(8'h01, 8'h00, 8'h00, 8'h00), lanes4(8'h30, 8'h00, 8'h00, 8'h00));
    wait_result("s5_subnorm", sub_exp);

    // 2^24 + 3: one dropped bit exactly half, odd kept -> round up to mant 2.
    start_vec(8'd5, 4'sd0, 4'sd0);
    for (int i = 0; i < 4; i++) begin
      beat("rnd_up", lanes4(8'h70, 8'h70, 8'h70, 8'h70), lanes4(8'h70, 8'h70, 8'h70, 8'h70));
    end
    beat("rnd_up", lanes4(8'h11, 8'h90, 8'h00, 8'h00), lanes4(8'h13, 8'h14, 8'h00, 8'h00));
    wait_result("rnd_up", 32'h45800002);

    // 2^24 + 1: tie with even kept -> stays.
    start_vec(8'd5, 4'sd0, 4'sd0);
    for (int i = 0; i < 4; i++) begin
      beat("rnd_even", lanes4(8'h70, 8'h70, 8'h70, 8'h70), lanes4(8'h70, 8'h70, 8'h70, 8'h70));
    end
    beat("rnd_even", lanes4(8'h11, 8'h90, 8'h00, 8'h00), lanes4(8'h11, 8'h12, 8'h00, 8'h00));
    wait_result("rnd_even", 32'h45800000);

    // Reset mid-vector discards everything.
    start_vec(8'd4, 4'sd0, 4'sd0);
    beat("s6a", ones, ones);
    beat("s6b", ones, ones);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("s6_ready", 32'(in_ready), 32'd0);
    check_eq("s6_busy", 32'(busy), 32'd0);
    check_eq("s6_result", result, 32'd0);
    start_vec(8'd1, 4'sd0, 4'sd0);
    beat("s6c", ones, ones);
    wait_result("s6_fresh", 32'h40800000);

    start_vec(8'd0, 4'sd0, 4'sd0);
    check_eq("s7_ready", 32'(in_ready), 32'd0);
    wait_result("s7_zero", 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
